csr_bus_arbiter: RTL

//  Shares the single CSR peripheral bus (read/modify/wdata/addr -> rdata/valid) between two requesters:
//   - requester 0: the core.
//   - requester 1: the debug/loader port.

---
 rtl/csr_bus_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/csr_bus_arbiter.sv
// ---------------------------------------------------------------------------
// csr_bus_arbiter
//
// Shares one CSR peripheral bus between two requesters (0 = core,
// 1 = debug/loader). Each access runs ISSUE -> COLLECT -> DONE: the bus
// fields are driven for one cycle, the registered peripheral responses are
// merged, and a one-cycle done pulse returns data and an error flag.
// An address decoded by zero or several peripherals is flagged as an error.
//
// Ports
//   clk, rstn              clock, asynchronous active-low reset
//   req0/req1              request, held until done, fields stable meanwhile
//   read0/1, modify0/1     read strobe and modify code of each requester
//   addr0/1, wdata0/1      CSR address and write data of each requester
//   done0/done1            one-cycle completion pulse to the owner
//   rdata_o, err_o         merged response, qualified by done0|done1
//   csr_read, csr_modify   bus strobes, driven during ISSUE only
//   csr_addr, csr_wdata    bus address / write data
//   csr_valid, csr_rdata   per-peripheral registered responses
// ---------------------------------------------------------------------------
module csr_bus_arbiter #(
    parameter int SLAVES = 6
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   req0,
    input  logic                   req1,
    input  logic                   read0,
    input  logic                   read1,
    input  logic [2:0]             modify0,
    input  logic [2:0]             modify1,
    input  logic [11:0]            addr0,
    input  logic [11:0]            addr1,
    input  logic [31:0]            wdata0,
    input  logic [31:0]            wdata1,
    output logic                   done0,
    output logic                   done1,
    output logic [31:0]            rdata_o,
    output logic                   err_o,
    output logic                   csr_read,
    output logic [2:0]             csr_modify,
    output logic [11:0]            csr_addr,
    output logic [31:0]            csr_wdata,
    input  logic [SLAVES-1:0]      csr_valid,
    input  logic [32*SLAVES-1:0]   csr_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        COLLECT,
        DONE
    } state_t;

    state_t      state, state_nx;
    logic        rr, rr_nx;
    logic        owner, owner_nx;
    logic        win;
    logic        read_nx;
    logic [2:0]  modify_nx;
    logic [11:0] addr_nx;
    logic [31:0] wdata_nx;
    logic        done0_nx, done1_nx;
    logic [31:0] rdata_nx;
    logic        err_nx;
    logic [31:0] merged_rdata;
    logic [4:0]  hit_count;

    // rr names the requester favoured on the next tie. It starts at the core
    // and is handed to the other side at every grant, so persistent
    // contention alternates 0,1,0,1.
    assign win = (req0 && req1) ? rr : req1;

    // OR-merge of all peripheral data (peripherals drive 0 when not valid)
    // and a count of how many peripherals claimed the address.
    always_comb begin
        merged_rdata = '0;
        hit_count    = '0;
        for (int i = 0; i < SLAVES; i++) begin
            merged_rdata = merged_rdata | csr_rdata[32*i +: 32];
            hit_count    = hit_count + 5'(csr_valid[i]);
        end
    end

    // Next-state and next-value logic for every registered output.
    always_comb begin
        state_nx  = state;
        rr_nx     = rr;
        owner_nx  = owner;
        read_nx   = csr_read;
        modify_nx = csr_modify;
        addr_nx   = csr_addr;
        wdata_nx  = csr_wdata;
        done0_nx  = 1'b0;
        done1_nx  = 1'b0;
        rdata_nx  = rdata_o;
        err_nx    = err_o;

        unique case (state)
            IDLE, DONE: begin
                // DONE arbitrates exactly like IDLE; an owner still holding
                // req here starts a fresh transaction.
                if (req0 || req1) begin
                    state_nx  = ISSUE;
                    owner_nx  = win;
                    rr_nx     = ~win;
                    read_nx   = win ? read1   : read0;
                    modify_nx = win ? modify1 : modify0;
                    addr_nx   = win ? addr1   : addr0;
                    wdata_nx  = win ? wdata1  : wdata0;
                end else begin
                    state_nx = IDLE;
                    addr_nx  = '0;
                end
            end
            ISSUE: begin
                // Strobes last one cycle so a modify has a single side effect.
                state_nx  = COLLECT;
                read_nx   = 1'b0;
                modify_nx = 3'b000;
            end
            COLLECT: begin
                state_nx = DONE;
                rdata_nx = merged_rdata;
                err_nx   = (hit_count != 5'd1);
                done0_nx = ~owner;
                done1_nx = owner;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            rr         <= 1'b0;
            owner      <= 1'b0;
            csr_read   <= 1'b0;
            csr_modify <= 3'b000;
            csr_addr   <= '0;
            csr_wdata  <= '0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            rdata_o    <= '0;
            err_o      <= 1'b0;
        end else begin
            state      <= state_nx;
            rr         <= rr_nx;
            owner      <= owner_nx;
            csr_read   <= read_nx;
            csr_modify <= modify_nx;
            csr_addr   <= addr_nx;
            csr_wdata  <= wdata_nx;
            done0      <= done0_nx;
            done1      <= done1_nx;
            rdata_o    <= rdata_nx;
            err_o      <= err_nx;
        end
    end

endmodule
